// File: rtl/snes_pad_pkg.sv
// snes_pad_pkg
// Shared definitions for the SNES pad reader: FSM state encoding, button bit
// positions in the active-high button word, the ID nibble mask and a helper
// that recognises a connected pad from its raw serial frame.
package snes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    SETTLE = 3'd2,
    CLK_LO = 3'd3,
    CLK_HI = 3'd4,
    DONE   = 3'd5
  } pad_state_t;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  localparam logic [15:0] ID_MASK = 16'hF000;

  // A genuine pad drives its four trailing ID bits high (released level);
  // with nothing plugged in the board pull-down makes them read low.
  function automatic logic pad_id_ok(input logic [15:0] raw);
    return (raw & ID_MASK) == ID_MASK;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2
// Generic two-flop synchronizer for bringing asynchronous inputs into the
// clock domain of clk. Reset clears both stages.
//   clk   in          destination clock
//   reset in          synchronous, active-high reset
//   d     in  WIDTH   asynchronous input
//   q     out WIDTH   synchronized output (two cycles of latency)
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/snes_pad_reader.sv
// snes_pad_reader
// Host-side SNES controller reader. Every poll period it strobes pad_latch,
// clocks the 16-bit active-low serial stream out of the pad with pad_clk and
// publishes an active-high button word plus a presence flag.
//   clk       in      system clock
//   reset     in      synchronous, active-high reset
//   enable    in      polling allowed (only checked at the poll trigger)
//   pad_data  in      serial data from pad, active-low, asynchronous
//   pad_latch out     latch strobe to pad, active-high
//   pad_clk   out     shift clock to pad, idles high
//   buttons   out 16  active-high buttons (0 when no pad present)
//   present   out     pad detected in last completed frame
//   valid     out     one-cycle pulse when buttons/present update
//
// state  | meaning
// IDLE   | waiting for the poll trigger with enable high
// LATCH  | pad_latch high, pad captures its buttons
// SETTLE | latch released, bit 0 valid on pad_data, sampled at end
// CLK_LO | pad_clk low half period
// CLK_HI | pad_clk high half period, bit_idx sampled at end
// DONE   | publish buttons/present, pulse valid
module snes_pad_reader
  import snes_pad_pkg::*;
#(
  parameter int LATCH_CYCLES = 256,
  parameter int HALF_CYCLES  = 64,
  parameter int POLL_CYCLES  = 357955
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pad_data,
  output logic        pad_latch,
  output logic        pad_clk,
  output logic [15:0] buttons,
  output logic        present,
  output logic        valid
);

  localparam int PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX);
  localparam int POLL_W    = $clog2(POLL_CYCLES);

  localparam logic [PHASE_W-1:0] LATCH_LOAD = PHASE_W'(LATCH_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HALF_LOAD  = PHASE_W'(HALF_CYCLES - 1);
  localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);

  // The sample point sits HALF_CYCLES-1 cycles after the pad's data change,
  // which only covers the synchronizer latency from 4 upwards; a frame must
  // also fit inside one poll period so the trigger always finds IDLE.
  if (HALF_CYCLES < 4) begin : g_half_chk
    $error("snes_pad_reader: HALF_CYCLES must be at least 4");
  end
  if (POLL_CYCLES <= LATCH_CYCLES + 31 * HALF_CYCLES + 2) begin : g_poll_chk
    $error("snes_pad_reader: POLL_CYCLES too short for one frame");
  end

  pad_state_t         state, state_nxt;
  logic [PHASE_W-1:0] phase, phase_nxt;
  logic [3:0]         bit_idx, bit_idx_nxt;
  logic [POLL_W-1:0]  poll_cnt;
  logic [15:0]        raw;
  logic               data_sync;
  logic               poll_tick;
  logic               phase_done;
  logic               sample_en;

  sync2 #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pad_data),
    .q     (data_sync)
  );

  assign poll_tick  = (poll_cnt == POLL_LAST);
  assign phase_done = (phase == '0);

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase_done ? phase : phase - 1'b1;
    bit_idx_nxt = bit_idx;
    sample_en   = 1'b0;
    case (state)
      IDLE: begin
        if (poll_tick && enable) begin
          state_nxt   = LATCH;
          phase_nxt   = LATCH_LOAD;
          bit_idx_nxt = 4'd0;
        end
      end
      LATCH: begin
        if (phase_done) begin
          state_nxt = SETTLE;
          phase_nxt = HALF_LOAD;
        end
      end
      SETTLE: begin
        if (phase_done) begin
          sample_en   = 1'b1;
          bit_idx_nxt = 4'd1;
          state_nxt   = CLK_LO;
          phase_nxt   = HALF_LOAD;
        end
      end
      CLK_LO: begin
        if (phase_done) begin
          state_nxt = CLK_HI;
          phase_nxt = HALF_LOAD;
        end
      end
      CLK_HI: begin
        if (phase_done) begin
          sample_en = 1'b1;
          if (bit_idx == 4'd15) begin
            state_nxt = DONE;
          end else begin
            bit_idx_nxt = bit_idx + 4'd1;
            state_nxt   = CLK_LO;
            phase_nxt   = HALF_LOAD;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pad-facing strobes are registered from the next state so they change
  // exactly on the state transition edge without combinational glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      bit_idx   <= 4'd0;
      poll_cnt  <= '0;
      raw       <= 16'h0000;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b1;
      buttons   <= 16'h0000;
      present   <= 1'b0;
      valid     <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      bit_idx   <= bit_idx_nxt;
      poll_cnt  <= poll_tick ? '0 : poll_cnt + 1'b1;
      pad_latch <= (state_nxt == LATCH);
      pad_clk   <= (state_nxt != CLK_LO);
      valid     <= (state == DONE);
      if (sample_en) begin
        raw[bit_idx] <= data_sync;
      end
      if (state == DONE) begin
        present <= pad_id_ok(raw);
        buttons <= pad_id_ok(raw) ? ~raw : 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_snes_pad_reader.sv
module tb_snes_pad_reader;

  localparam int LATCH = 4;
  localparam int HALF  = 4;
  localparam int POLL  = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        pad_data;
  logic        pad_latch;
  logic        pad_clk;
  logic [15:0] buttons;
  logic        present;
  logic        valid;

  int checks = 0;
  int fails  = 0;

  snes_pad_reader #(
    .LATCH_CYCLES (LATCH),
    .HALF_CYCLES  (HALF),
    .POLL_CYCLES  (POLL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .buttons   (buttons),
    .present   (present),
    .valid     (valid)
  );

  always #5 clk = ~clk;

  // Behavioural pad: parallel load while latched, shift on pad_clk rise.
  logic [15:0] pad_value = 16'hF6F7;
  logic [15:0] pad_sr = 16'hFFFF;
  logic        pad_connected = 1'b1;

  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) pad_sr <= pad_value;
    else           pad_sr <= {1'b1, pad_sr[15:1]};
  end
  assign pad_data = pad_connected ? pad_sr[0] : 1'b0;

  // Event monitors sampled away from the active edge.
  int cyc = 0;
  int latch_rises = 0, latch_rise_cyc = 0;
  int clk_lows = 0, clk_rises = 0;
  int valid_cnt = 0, valid_cyc = 0;
  logic latch_prev = 1'b0, clk_prev = 1'b1;
  int rel_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pad_latch && !latch_prev) begin
      latch_rises++;
      latch_rise_cyc = cyc;
    end
    if (!pad_clk && clk_prev) clk_lows++;
    if (pad_clk && !clk_prev) clk_rises++;
    if (valid) begin
      valid_cnt++;
      valid_cyc = cyc;
    end
    latch_prev = pad_latch;
    clk_prev   = pad_clk;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_latch(input int budget, output bit ok);
    int start = latch_rises;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (latch_rises != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int start = valid_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (valid_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b1;
    enable = 1'b1;
    pad_connected = 1'b1;
    pad_value = 16'hF6F7;
    repeat (3) tick();
    checks++; if (pad_latch !== 1'b0) begin fails++; $display("FAIL reset_latch got %b want 0", pad_latch); end
    checks++; if (pad_clk !== 1'b1) begin fails++; $display("FAIL reset_clk got %b want 1", pad_clk); end
    checks++; if (buttons !== 16'h0000) begin fails++; $display("FAIL reset_buttons got %h want 0000", buttons); end
    checks++; if (present !== 1'b0) begin fails++; $display("FAIL reset_present got %b want 0", present); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
    reset = 1'b0;
    rel_cyc = cyc;
    wait_latch(POLL + 20, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL first_latch timeout"); end
    else if (latch_rise_cyc - rel_cyc !== POLL) begin
      fails++; $display("FAIL first_latch_delay got %0d want %0d", latch_rise_cyc - rel_cyc, POLL);
    end
  endtask

  task automatic test_press();
    bit ok;
    int rise;
    wait_latch(POLL + 20, ok);
    checks++; if (!ok) begin fails++; $display("FAIL press_latch timeout"); end
    rise = latch_rise_cyc;
    wait_valid(POLL, ok);
    checks++; if (!ok) begin fails++; $display("FAIL press_valid timeout"); end
    checks++; if (valid_cyc - rise !== 129) begin fails++; $display("FAIL press_latency got %0d want 129", valid_cyc - rise); end
    checks++; if (buttons !== 16'h0908) begin fails++; $display("FAIL press_buttons got %h want 0908", buttons); end
    checks++; if (present !== 1'b1) begin fails++; $display("FAIL press_present got %b want 1", present); end
    tick();
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL press_valid_width got %b want 0", valid); end
  endtask

  task automatic test_no_pad();
    bit ok;
    pad_connected = 1'b0;
    wait_valid(2 * POLL, ok);
    checks++; if (!ok) begin fails++; $display("FAIL nopad_valid timeout"); end
    checks++; if (present !== 1'b0) begin fails++; $display("FAIL nopad_present got %b want 0", present); end
    checks++; if (buttons !== 16'h0000) begin fails++; $display("FAIL nopad_buttons got %h want 0000", buttons); end
    wait_valid(2 * POLL, ok);
    checks++; if (!ok) begin fails++; $display("FAIL nopad_second_valid timeout"); end
    pad_connected = 1'b1;
  endtask

  task automatic test_drop_enable();
    bit ok;
    int lows0, valid0, rises0;
    pad_value = 16'hF6F7;
    wait_latch(2 * POLL, ok);
    checks++; if (!ok) begin fails++; $display("FAIL drop_latch timeout"); end
    enable = 1'b0;
    lows0 = clk_lows;
    valid0 = valid_cnt;
    rises0 = latch_rises;
    repeat (600) tick();
    checks++; if (clk_lows - lows0 !== 15) begin fails++; $display("FAIL drop_clk_lows got %0d want 15", clk_lows - lows0); end
    checks++; if (valid_cnt - valid0 !== 1) begin fails++; $display("FAIL drop_valids got %0d want 1", valid_cnt - valid0); end
    checks++; if (latch_rises - rises0 !== 0) begin fails++; $display("FAIL drop_extra_latch got %0d want 0", latch_rises - rises0); end
    checks++; if (buttons !== 16'h0908) begin fails++; $display("FAIL drop_buttons got %h want 0908", buttons); end
  endtask

  task automatic test_enable_gate();
    bit ok;
    bit clk_low_seen = 1'b0;
    int rises0 = latch_rises;
    int valid0 = valid_cnt;
    int expect_cyc;
    enable = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (pad_clk !== 1'b1) clk_low_seen = 1'b1;
    end
    checks++; if (latch_rises - rises0 !== 0) begin fails++; $display("FAIL gate_latch got %0d rises want 0", latch_rises - rises0); end
    checks++; if (clk_low_seen !== 1'b0) begin fails++; $display("FAIL gate_clk got low want idle high"); end
    checks++; if (valid_cnt - valid0 !== 0) begin fails++; $display("FAIL gate_valid got %0d want 0", valid_cnt - valid0); end
    while ((cyc - rel_cyc) % POLL != 100) tick();
    enable = 1'b1;
    expect_cyc = rel_cyc + POLL * (((cyc - rel_cyc) / POLL) + 1);
    wait_latch(2 * POLL, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL gate_resume timeout"); end
    else if (latch_rise_cyc !== expect_cyc) begin
      fails++; $display("FAIL gate_resume_cyc got %0d want %0d", latch_rise_cyc, expect_cyc);
    end
    wait_valid(POLL, ok);
  endtask

  task automatic test_pad_change();
    bit ok;
    bit changed = 1'b0;
    pad_value = 16'hFFFE;
    wait_valid(2 * POLL, ok);
    checks++; if (!ok) begin fails++; $display("FAIL change1_valid timeout"); end
    checks++; if (buttons !== 16'h0001) begin fails++; $display("FAIL change1_buttons got %h want 0001", buttons); end
    pad_value = 16'hFFFD;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (buttons !== 16'h0001) changed = 1'b1;
    end
    checks++; if (changed !== 1'b0) begin fails++; $display("FAIL change_hold got changed want stable 0001"); end
    wait_valid(2 * POLL, ok);
    checks++; if (!ok) begin fails++; $display("FAIL change2_valid timeout"); end
    checks++; if (buttons !== 16'h0002) begin fails++; $display("FAIL change2_buttons got %h want 0002", buttons); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int rises0;
    int valid0;
    pad_value = 16'hF6F7;
    wait_latch(2 * POLL, ok);
    checks++; if (!ok) begin fails++; $display("FAIL mid_latch timeout"); end
    rises0 = clk_rises;
    for (int i = 0; i < POLL && (clk_rises - rises0) < 7; i++) tick();
    tick();
    reset = 1'b1;
    tick();
    checks++; if (pad_clk !== 1'b1) begin fails++; $display("FAIL mid_clk got %b want 1", pad_clk); end
    checks++; if (pad_latch !== 1'b0) begin fails++; $display("FAIL mid_latch_out got %b want 0", pad_latch); end
    checks++; if (buttons !== 16'h0000) begin fails++; $display("FAIL mid_buttons got %h want 0000", buttons); end
    checks++; if (present !== 1'b0) begin fails++; $display("FAIL mid_present got %b want 0", present); end
    reset = 1'b0;
    rel_cyc = cyc;
    valid0 = valid_cnt;
    wait_latch(POLL + 20, ok);
    checks++; if (!ok) begin fails++; $display("FAIL mid_relatch timeout"); end
    checks++; if (valid_cnt !== valid0) begin fails++; $display("FAIL mid_partial_valid got %0d pulses want 0", valid_cnt - valid0); end
    wait_valid(POLL, ok);
    checks++; if (!ok) begin fails++; $display("FAIL mid_valid timeout"); end
    checks++; if (buttons !== 16'h0908) begin fails++; $display("FAIL mid_buttons_after got %h want 0908", buttons); end
    checks++; if (present !== 1'b1) begin fails++; $display("FAIL mid_present_after got %b want 1", present); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_no_pad();
    test_drop_enable();
    test_enable_gate();
    test_pad_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
